// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and counter width for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_e;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring-divide iteration over a shared 64-bit accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               div_mode,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               q_bit
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // Multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, operand};
        q_bit    = 1'b0;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (div_mode) begin
            q_bit    = ~trial[WIDTH];
            acc_next = {(q_bit ? trial[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1]), acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO; stalls the pipeline while busy.
// Optional MULDIV_DIV0_FLAG_EN enables the one-cycle divide-by-zero flag on div0.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    input  logic             flush,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div0
);
    state_e               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2*WIDTH-1:0]   acc_reg, step_acc, prod;
    logic [WIDTH-1:0]     opnd_reg, hi_reg, lo_reg, a_abs, b_abs;
    logic                 div_reg, neg_q_reg, neg_r_reg, done_reg, step_q;
    logic                 accept, mt_hi, mt_lo, finish, signed_op, mul_op;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign mul_op    = (op == OP_MULT) || (op == OP_MULTU);
    assign a_abs     = (signed_op && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
    assign b_abs     = (signed_op && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;
    assign prod      = neg_q_reg ? -acc_reg : acc_reg;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_reg),
        .operand  (opnd_reg),
        .div_mode (div_reg),
        .acc_next (step_acc),
        .q_bit    (step_q)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        mt_hi      = 1'b0;
        mt_lo      = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: if (start) begin
                case (op)
                    OP_MULT, OP_MULTU: accept = 1'b1;
                    OP_DIV, OP_DIVU:   accept = (Rdata2 != '0);
                    OP_MTHI:           mt_hi  = 1'b1;
                    OP_MTLO:           mt_lo  = 1'b1;
                    default:           ;
                endcase
                if (accept) state_next = CALC;
            end
            CALC: begin
                if (flush)              state_next = IDLE;
                else if (cnt_reg == '0) state_next = SIGN;
            end
            SIGN: begin
                state_next = IDLE;
                finish     = ~flush;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            opnd_reg  <= '0;
            div_reg   <= 1'b0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= finish;
            if (accept) begin
                cnt_reg   <= CNT_W'(WIDTH - 1);
                div_reg   <= ~mul_op;
                acc_reg   <= {{WIDTH{1'b0}}, (mul_op ? b_abs : a_abs)};
                opnd_reg  <= mul_op ? a_abs : b_abs;
                neg_q_reg <= signed_op & (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                neg_r_reg <= signed_op & Rdata1[WIDTH-1];
            end else if (state_reg == CALC) begin
                acc_reg <= {step_acc[2*WIDTH-1:1], step_acc[0] | step_q};
                if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
            end
            if (mt_hi) hi_reg <= Rdata1;
            if (mt_lo) lo_reg <= Rdata1;
            if (finish) begin
                if (div_reg) begin
                    // Quotient sign follows operand signs; remainder follows the dividend.
                    hi_reg <= neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
                    lo_reg <= neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
                end else begin
                    {hi_reg, lo_reg} <= prod;
                end
            end
        end
    end

`ifdef MULDIV_DIV0_FLAG_EN
    logic div0_reg;
    logic div_zero;
    assign div_zero = (state_reg == IDLE) && start && is_div(op) && (Rdata2 == '0);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) div0_reg <= 1'b0;
        else        div0_reg <= div_zero;
    end
    assign div0 = div0_reg;
`else
    assign div0 = 1'b0;
`endif

    assign HI    = hi_reg;
    assign LO    = lo_reg;
    assign busy  = (state_reg != IDLE);
    assign stall = busy & (start | rd_hilo);
    assign done  = done_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a scoreboard queue of expected {HI,LO}.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] Rdata1 = '0;
    logic [31:0] Rdata2 = '0;
    logic        flush = 1'b0;
    logic        rd_hilo = 1'b0;
    logic [31:0] HI, LO;
    logic        busy, stall, done, div0;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    muldiv_seq #(.WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .op(op),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .flush(flush), .rd_hilo(rd_hilo),
        .HI(HI), .LO(LO), .busy(busy), .stall(stall), .done(done), .div0(div0)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        start = 1'b1; op = o; Rdata1 = a; Rdata2 = b;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int busy_n);
        int n = 0;
        logic [63:0] exp = '0;
        busy_n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (busy === 1'b1) busy_n++;
            @(negedge CLK);
            n++;
        end
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check(tag, {HI, LO}, exp);
        $display("txn %s hi=%h lo=%h cycles=%0d", tag, HI, LO, n);
    endtask

    initial begin
        int bc;
        int n;
        int bad;
        logic exp_div0;

        // Reset state
        #12;
        check("reset_state", {HI, LO}, 64'd0);
        check("reset_flags", {60'd0, busy, stall, done, div0}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Signed multiply with latency and one-cycle done
        exp_q.push_back(64'hFFFFFFFF_FFFFFFFA);
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3);
        wait_done("mult_neg", bc);
        check("mult_busy_cycles", 64'(bc), 64'd33);
        check("mult_busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge CLK);
        check("mult_done_width", {63'd0, done}, 64'd0);

        exp_q.push_back(64'hFFFFFFFE_00000001);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu_max", bc);

        exp_q.push_back(64'hFFFFFFFF_FFFFFFDD);
        issue(OP_MULT, 32'hFFFFFFFB, 32'd7);
        wait_done("mult_m5x7", bc);

        exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done("div_m7_2", bc);

        exp_q.push_back(64'h00000001_FFFFFFFD);
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done("div_7_m2", bc);

        exp_q.push_back(64'h00000000_80000000);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", bc);

        exp_q.push_back(64'h00000002_0000000E);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("divu_100_7", bc);

        // MTHI/MTLO then divide by zero
        issue(OP_MTHI, 32'd5, 32'd0);
        check("mthi", {32'd0, HI}, 64'd5);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        issue(OP_MTLO, 32'd6, 32'd0);
        check("mtlo", {HI, LO}, {32'd5, 32'd6});
`ifdef MULDIV_DIV0_FLAG_EN
        exp_div0 = 1'b1;
`else
        exp_div0 = 1'b0;
`endif
        issue(OP_DIVU, 32'd100, 32'd0);
        check("div0_flag", {62'd0, busy, div0}, {62'd0, 1'b0, exp_div0});
        @(negedge CLK);
        check("div0_pulse_end", {62'd0, busy, div0}, 64'd0);
        check("div0_hilo", {HI, LO}, {32'd5, 32'd6});
        $display("txn divu_by_zero hi=%h lo=%h", HI, LO);

        // Flush mid-operation
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_hilo", {HI, LO}, {32'd5, 32'd6});
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (done !== 1'b0) bad++;
        end
        check("flush_no_done", 64'(bad), 64'd0);
        $display("txn divu_flush hi=%h lo=%h", HI, LO);

        exp_q.push_back(64'h00000000_0000000C);
        issue(OP_MULTU, 32'd3, 32'd4);
        wait_done("multu_3x4", bc);

        // Stall from rd_hilo and a held second start
        exp_q.push_back(64'h00000003_00000000);
        issue(OP_MULT, 32'h00010000, 32'h00030000);
        start = 1'b1; op = OP_MTLO; Rdata1 = 32'h77; Rdata2 = '0; rd_hilo = 1'b1;
        n = 0;
        bad = 0;
        do begin
            @(negedge CLK);
            n++;
            if (done !== 1'b1 && stall !== 1'b1) bad++;
        end while (done !== 1'b1 && n < 100);
        check("stall_held", 64'(bad), 64'd0);
        check("stall_len", 64'(n), 64'd33);
        check("stall_drop", {62'd0, stall, done}, 64'd1);
        check("stall_mult", {HI, LO}, exp_q.size() > 0 ? exp_q.pop_front() : 64'd0);
        @(negedge CLK);
        start = 1'b0; rd_hilo = 1'b0;
        check("stall_second_op", {HI, LO}, {32'd3, 32'h77});
        $display("txn stall_mtlo hi=%h lo=%h cycles=%0d", HI, LO, n);

        // Asynchronous reset mid-operation
        issue(OP_MULTU, 32'd3, 32'd4);
        repeat (5) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("async_reset", {HI, LO}, 64'd0);
        check("async_reset_busy", {62'd0, busy, done}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        $display("txn async_reset hi=%h lo=%h", HI, LO);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
